// File: rtl/display_driver.sv
// Six-digit multiplexed seven-segment driver for a signed 16-bit result.
// A sequential double-dabble unit produces sign plus 5 BCD digits, which are scanned with leading-zero blanking.
module display_driver #(
   parameter int SCAN_DIV = 50000
) (
   input  logic               clk,
   input  logic               nRST,
   input  logic signed [15:0] value,
   input  logic               valid,
   output logic [6:0]         seg,
   output logic [5:0]         an,
   output logic               busy,
   output logic               done,
   output logic [19:0]        bcd,
   output logic               neg
);
   localparam int               CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
   localparam logic [6:0]       SEG_MINUS = 7'h3F;
   localparam logic [6:0]       SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

   state_t           state_q, state_d;
   logic             valid_q, valid_d;
   logic             pending_q, pending_d;
   logic             neg_w_q, neg_w_d;
   logic [15:0]      mag_q, mag_d;
   logic [19:0]      work_q, work_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [19:0]      bcd_q, bcd_d;
   logic             neg_q, neg_d;
   logic             shown_q, shown_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [2:0]       dig_q, dig_d;
   logic [6:0]       seg_q, seg_d;
   logic [5:0]       an_q, an_d;
   logic             rise;
   logic             wrap;
   logic [19:0]      upper;

   function automatic logic [19:0] dabble_adj(input logic [19:0] w);
      logic [19:0] r;
      r = w;
      for (int i = 0; i < 5; i++) begin
         if (w[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = w[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 7'h40;
         4'd1:    seg_code = 7'h79;
         4'd2:    seg_code = 7'h24;
         4'd3:    seg_code = 7'h30;
         4'd4:    seg_code = 7'h19;
         4'd5:    seg_code = 7'h12;
         4'd6:    seg_code = 7'h02;
         4'd7:    seg_code = 7'h78;
         4'd8:    seg_code = 7'h00;
         4'd9:    seg_code = 7'h10;
         default: seg_code = SEG_BLANK;
      endcase
   endfunction

   always_comb begin
      rise      = valid & ~valid_q;
      valid_d   = valid;
      state_d   = state_q;
      pending_d = pending_q;
      neg_w_d   = neg_w_q;
      mag_d     = mag_q;
      work_d    = work_q;
      bit_cnt_d = bit_cnt_q;
      bcd_d     = bcd_q;
      neg_d     = neg_q;
      shown_d   = shown_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise || pending_q) begin
               state_d   = CONV;
               neg_w_d   = value[15];
               mag_d     = value[15] ? $unsigned(-value) : $unsigned(value);
               work_d    = '0;
               bit_cnt_d = '0;
               pending_d = 1'b0;
            end
         end
         CONV: begin
            if (rise) pending_d = 1'b1;
            {work_d, mag_d} = {dabble_adj(work_q), mag_q} << 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) state_d = COMMIT;
         end
         COMMIT: begin
            if (rise) pending_d = 1'b1;
            bcd_d   = work_q;
            neg_d   = neg_w_q;
            shown_d = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // busy stays up through the done cycle so it brackets the whole request
      busy_d = (state_d != IDLE) || (state_q == COMMIT);

      wrap       = (scan_cnt_q == CNT_MAX);
      scan_cnt_d = wrap ? '0 : scan_cnt_q + 1'b1;
      dig_d      = wrap ? ((dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1) : dig_q;

      // Content follows the committing values so a commit shows on the next cycle
      upper = bcd_d >> {dig_q, 2'b00};
      an_d  = ~(6'b000001 << dig_q);
      seg_d = SEG_BLANK;
      if (shown_d) begin
         if (dig_q == 3'd5) seg_d = neg_d ? SEG_MINUS : SEG_BLANK;
         else if (dig_q == 3'd0 || upper != 20'd0) seg_d = seg_code(upper[3:0]);
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         pending_q  <= 1'b0;
         neg_w_q    <= 1'b0;
         mag_q      <= '0;
         work_q     <= '0;
         bit_cnt_q  <= '0;
         bcd_q      <= '0;
         neg_q      <= 1'b0;
         shown_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         scan_cnt_q <= '0;
         dig_q      <= '0;
         seg_q      <= SEG_BLANK;
         an_q       <= 6'b111111;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         pending_q  <= pending_d;
         neg_w_q    <= neg_w_d;
         mag_q      <= mag_d;
         work_q     <= work_d;
         bit_cnt_q  <= bit_cnt_d;
         bcd_q      <= bcd_d;
         neg_q      <= neg_d;
         shown_q    <= shown_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         scan_cnt_q <= scan_cnt_d;
         dig_q      <= dig_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
      end
   end

   assign seg  = seg_q;
   assign an   = an_q;
   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;
   assign neg  = neg_q;
endmodule

// File: tb/tb_display_driver.sv
// Scoreboard bench for display_driver: stimulus queues expected commits, a monitor checks each done pulse.
module tb_display_driver;
   logic               clk = 1'b0;
   logic               nRST = 1'b0;
   logic signed [15:0] value = '0;
   logic               valid = 1'b0;
   logic [6:0]         seg;
   logic [5:0]         an;
   logic               busy;
   logic               done;
   logic [19:0]        bcd;
   logic               neg;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [19:0] bcd;
      logic        neg;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   display_driver #(.SCAN_DIV(4)) dut (
      .clk(clk), .nRST(nRST), .value(value), .valid(valid),
      .seg(seg), .an(an), .busy(busy), .done(done), .bcd(bcd), .neg(neg)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every done pulse must match the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done cyc=%0d bcd=%05h", cyc, bcd);
         end else begin
            e = sb.pop_front();
            checks += 3;
            if (bcd !== e.bcd) begin
               errors++; $display("FAIL done_bcd got=%05h exp=%05h", bcd, e.bcd);
            end
            if (neg !== e.neg) begin
               errors++; $display("FAIL done_neg got=%0b exp=%0b", neg, e.neg);
            end
            if (cyc != e.cyc) begin
               errors++; $display("FAIL done_latency got_cyc=%0d exp_cyc=%0d", cyc, e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // One full 24-cycle scan window: each digit must appear 4 times with its expected code
   task automatic check_scan(input string tag, input logic [6:0] e5, input logic [6:0] e4,
                             input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0);
      logic [6:0] exp [6];
      int         hits [6];
      int         d;
      logic [5:0] oh;
      exp = '{e0, e1, e2, e3, e4, e5};
      for (int k = 0; k < 6; k++) hits[k] = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         d = -1;
         for (int k = 0; k < 6; k++) begin
            oh = ~(6'b000001 << k);
            if (an == oh) d = k;
         end
         checks++;
         if (d < 0) begin
            errors++; $display("FAIL %s_an got=%b not one-hot-low", tag, an);
         end else begin
            hits[d]++;
            if (seg !== exp[d]) begin
               errors++; $display("FAIL %s_seg digit=%0d got=%02h exp=%02h", tag, d, seg, exp[d]);
            end
         end
      end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (hits[k] != 4) begin
            errors++; $display("FAIL %s_dwell digit=%0d got=%0d exp=4", tag, k, hits[k]);
         end
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((busy || sb.size() != 0) && n < 120) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 120) begin
         errors++; $display("FAIL %s_timeout busy=%0b queued=%0d exp=idle", tag, busy, sb.size());
      end
   endtask

   task automatic convert(input logic [15:0] v, input logic [19:0] eb, input logic en,
                          input int hold, input string tag);
      exp_t e;
      @(negedge clk);
      value = v;
      valid = 1'b1;
      e.bcd = eb; e.neg = en; e.cyc = cyc + 18;
      sb.push_back(e);
      repeat (hold) @(negedge clk);
      valid = 1'b0;
      wait_idle(tag);
   endtask

   initial begin
      exp_t e;
      int   n0;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_an", 32'(an), 32'h3F);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_bcd", 32'(bcd), 0);
      chk("rst_neg", 32'(neg), 0);
      nRST = 1'b1;
      @(negedge clk);
      chk("first_an", 32'(an), 32'h3E);
      chk("first_seg", 32'(seg), 32'h7F);
      check_scan("blank", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

      convert(16'd12, 20'h00012, 1'b0, 1, "v12");
      check_scan("d12", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24);

      convert(16'hFFF7, 20'h00009, 1'b1, 1, "vm9");
      check_scan("dm9", 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10);

      convert(16'h8000, 20'h32768, 1'b1, 1, "vmin");
      check_scan("dmin", 7'h3F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00);

      // valid held high must not retrigger
      convert(16'h7FFF, 20'h32767, 1'b0, 40, "vmax");
      check_scan("dmax", 7'h7F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h78);

      convert(16'd0, 20'h00000, 1'b0, 1, "vzero");
      check_scan("dzero", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);

      convert(16'd1005, 20'h01005, 1'b0, 1, "v1005");
      check_scan("d1005", 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h12);

      // Re-trigger during CONV: one pending request, value sampled at IDLE exit
      @(negedge clk);
      value = 16'd1575;
      valid = 1'b1;
      n0 = cyc;
      e.bcd = 20'h01575; e.neg = 1'b0; e.cyc = n0 + 18;
      sb.push_back(e);
      e.bcd = 20'h00007; e.neg = 1'b0; e.cyc = n0 + 36;
      sb.push_back(e);
      repeat (5) @(negedge clk);
      value = 16'd7;
      valid = 1'b0;
      @(negedge clk);
      valid = 1'b1;
      repeat (3) @(negedge clk);
      valid = 1'b0;
      wait_idle("pend");
      check_scan("dpend", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78);

      // Reset in the middle of a conversion
      @(negedge clk);
      value = 16'd1234;
      valid = 1'b1;
      repeat (8) @(negedge clk);
      valid = 1'b0;
      nRST = 1'b0;
      #1;
      chk("mid_rst_seg", 32'(seg), 32'h7F);
      chk("mid_rst_an", 32'(an), 32'h3F);
      chk("mid_rst_bcd", 32'(bcd), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      repeat (2) @(negedge clk);
      chk("mid_rst_hold_an", 32'(an), 32'h3F);
      chk("mid_rst_done", 32'(done), 0);
      nRST = 1'b1;
      @(negedge clk);
      chk("post_rst_an", 32'(an), 32'h3E);
      check_scan("post_rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      chk("post_rst_bcd", 32'(bcd), 0);
      chk("sb_empty", 32'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
